// File: rtl/button_debounce_rx.sv
// Multi-pin button debouncer: synchronizer, per-pin debounce FSM, edge pulses,
// and an event queue that reports (pin, direction) with a sticky loss flag.
module button_debounce_rx #(
    parameter int unsigned  WIDTH       = 4,
    parameter int unsigned  SYNC_STAGES = 2,
    parameter int unsigned  LOG2DELAY   = 16,
    parameter int unsigned  FIFO_DEPTH  = 4,
    localparam int unsigned IDX_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic             evt_dir,
    output logic             ovf,
    input  logic             ovf_clr
);
    localparam int unsigned          PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned          CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [LOG2DELAY-1:0] WIN_LAST = '1;

    localparam logic [1:0] STABLE_LO = 2'd0;
    localparam logic [1:0] WAIT_HI   = 2'd1;
    localparam logic [1:0] STABLE_HI = 2'd2;
    localparam logic [1:0] WAIT_LO   = 2'd3;

    // Synchronizer chain; only the last stage is used downstream
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    logic [WIDTH-1:0] level_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        logic [1:0]           state_q, state_d;
        logic [LOG2DELAY-1:0] cnt_q, cnt_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Window counter runs only while the new value holds; any revert restarts
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            case (state_q)
                STABLE_LO: if (sync[i]) state_d = WAIT_HI;
                WAIT_HI: begin
                    if (!sync[i])              state_d = STABLE_LO;
                    else if (cnt_q == WIN_LAST) state_d = STABLE_HI;
                    else                        cnt_d   = cnt_q + 1'b1;
                end
                STABLE_HI: if (!sync[i]) state_d = WAIT_LO;
                WAIT_LO: begin
                    if (sync[i])               state_d = STABLE_HI;
                    else if (cnt_q == WIN_LAST) state_d = STABLE_LO;
                    else                        cnt_d   = cnt_q + 1'b1;
                end
                default: state_d = STABLE_LO;
            endcase
        end

        assign level_d[i] = (state_d == STABLE_HI) || (state_d == WAIT_LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            rise  <= '0;
            fall  <= '0;
        end else begin
            level <= level_d;
            rise  <= level_d & ~level;
            fall  <= ~level_d & level;
        end
    end

    logic [WIDTH-1:0] chg_c, pend_q, pend_d, pdir_q, pdir_d;
    logic             sel_vld_c, sel_dir_c, push_c, pop_c, full_c, loss_c;
    logic [IDX_W-1:0] sel_c;

    assign chg_c = level_d ^ level;

    // Lowest-index pending event wins the single push slot
    always_comb begin
        sel_vld_c = 1'b0;
        sel_dir_c = 1'b0;
        sel_c     = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_vld_c = 1'b1;
                sel_dir_c = pdir_q[i];
                sel_c     = IDX_W'(i);
            end
        end
    end

    logic [IDX_W-1:0] mem_idx [FIFO_DEPTH];
    logic             mem_dir [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q, rd_d, wr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] head_idx_d;
    logic             head_dir_d;

    assign full_c = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_c  = evt_valid && evt_ready;
    assign push_c = sel_vld_c && (!full_c || pop_c);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A fresh change overwrites an unpushed pending event and counts as a loss
    always_comb begin
        pend_d = pend_q;
        pdir_d = pdir_q;
        loss_c = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (push_c && (sel_c == IDX_W'(i))) pend_d[i] = 1'b0;
            if (chg_c[i]) begin
                if (pend_q[i] && !(push_c && (sel_c == IDX_W'(i)))) loss_c = 1'b1;
                pend_d[i] = 1'b1;
                pdir_d[i] = level_d[i];
            end
        end
    end

    // Head is precomputed so evt_idx/evt_dir come straight from flops
    always_comb begin
        count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        rd_d       = pop_c  ? ptr_inc(rd_q) : rd_q;
        wr_d       = push_c ? ptr_inc(wr_q) : wr_q;
        head_idx_d = '0;
        head_dir_d = 1'b0;
        if (count_d != '0) begin
            if (push_c && (wr_q == rd_d)) begin
                head_idx_d = sel_c;
                head_dir_d = sel_dir_c;
            end else begin
                head_idx_d = mem_idx[rd_d];
                head_dir_d = mem_dir[rd_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= '0;
            pdir_q    <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            evt_valid <= 1'b0;
            evt_idx   <= '0;
            evt_dir   <= 1'b0;
            ovf       <= 1'b0;
            for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
                mem_idx[k] <= '0;
                mem_dir[k] <= 1'b0;
            end
        end else begin
            pend_q    <= pend_d;
            pdir_q    <= pdir_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            count_q   <= count_d;
            evt_valid <= (count_d != '0);
            evt_idx   <= head_idx_d;
            evt_dir   <= head_dir_d;
            ovf       <= (ovf && !ovf_clr) || loss_c;
            if (push_c) begin
                mem_idx[wr_q] <= sel_c;
                mem_dir[wr_q] <= sel_dir_c;
            end
        end
    end

endmodule

// File: tb/tb_button_debounce_rx.sv
// Directed bench for button_debounce_rx (DELAY=8); events checked by a queue-based scoreboard.
module tb_button_debounce_rx;
    localparam int unsigned WIDTH       = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned LOG2DELAY   = 3;
    localparam int unsigned FIFO_DEPTH  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] pin_in = '0;
    logic [WIDTH-1:0] level, rise, fall;
    logic             evt_valid;
    logic             evt_ready = 1'b0;
    logic [1:0]       evt_idx;
    logic             evt_dir;
    logic             ovf;
    logic             ovf_clr = 1'b0;

    typedef struct packed {
        logic [1:0] idx;
        logic       dir;
    } evt_t;

    evt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    button_debounce_rx #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES),
        .LOG2DELAY(LOG2DELAY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pin_in(pin_in),
        .level(level), .rise(rise), .fall(fall),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_idx(evt_idx), .evt_dir(evt_dir),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_evt(input logic [1:0] idx, input logic dir);
        evt_t e;
        e.idx = idx;
        e.dir = dir;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted beat must match the oldest expected event
    always @(negedge clk) begin
        evt_t e;
        if (rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL evt_unexpected: got idx %0d dir %0d, expected no event", evt_idx, evt_dir);
            end else begin
                e = exp_q.pop_front();
                check("evt_idx", 32'(evt_idx), 32'(e.idx));
                check("evt_dir", 32'(evt_dir), 32'(e.dir));
            end
        end
    end

    initial begin
        // Reset values
        tick(2);
        check("rst_level", 32'(level), 32'h0);
        check("rst_pulses", 32'({rise, fall}), 32'h0);
        check("rst_evt", 32'({evt_valid, evt_idx, evt_dir}), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Clean rise on pin 0, consumer always ready
        evt_ready = 1'b1;
        pin_in[0] = 1'b1;
        expect_evt(2'd0, 1'b1);
        tick(10);
        check("a_level_early", 32'(level), 32'h0);
        tick(1);
        check("a_level", 32'(level), 32'h1);
        check("a_rise", 32'(rise), 32'h1);
        tick(1);
        check("a_rise_clear", 32'(rise), 32'h0);
        check("a_valid", 32'(evt_valid), 32'h1);
        tick(1);
        check("a_valid_once", 32'(evt_valid), 32'h0);
        pin_in[0] = 1'b0;
        expect_evt(2'd0, 1'b0);
        tick(11);
        check("a_level_fall", 32'(level), 32'h0);
        check("a_fall", 32'(fall), 32'h1);
        tick(3);
        check("a_drained", 32'(evt_valid), 32'h0);

        // Glitch shorter than the window is rejected
        pin_in[1] = 1'b1;
        tick(5);
        pin_in[1] = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick(1);
            check("b_glitch", 32'({level, rise, evt_valid}), 32'h0);
        end

        // Simultaneous rise on all pins queues in index order
        evt_ready = 1'b0;
        pin_in = 4'hF;
        for (int p = 0; p < 4; p++) expect_evt(2'(p), 1'b1);
        tick(11);
        check("c_level", 32'(level), 32'hF);
        check("c_rise", 32'(rise), 32'hF);
        tick(5);
        check("c_head", 32'({evt_valid, evt_idx, evt_dir}), 32'b1001);
        check("c_ovf", 32'(ovf), 32'h0);
        evt_ready = 1'b1;
        tick(4);
        check("c_drained", 32'(evt_valid), 32'h0);
        evt_ready = 1'b0;

        // Full queue, pin 2 changes twice before space: loss flagged
        pin_in = 4'h0;
        for (int p = 0; p < 4; p++) expect_evt(2'(p), 1'b0);
        tick(16);
        check("d_head", 32'({evt_valid, evt_idx, evt_dir}), 32'b1000);
        pin_in[2] = 1'b1;
        tick(11);
        check("d_level_hi", 32'(level), 32'h4);
        check("d_ovf_none", 32'(ovf), 32'h0);
        pin_in[2] = 1'b0;
        expect_evt(2'd2, 1'b0);
        tick(11);
        check("d_level_lo", 32'(level), 32'h0);
        check("d_ovf_set", 32'(ovf), 32'h1);
        check("d_head_kept", 32'({evt_valid, evt_idx, evt_dir}), 32'b1000);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("d_ovf_clr", 32'(ovf), 32'h0);
        evt_ready = 1'b1;
        tick(5);
        check("d_drained", 32'(evt_valid), 32'h0);

        // Reset mid-window on pin 3 discards it; held pin rises after full latency
        check("e_sb_empty", 32'(exp_q.size()), 32'h0);
        pin_in[3] = 1'b1;
        tick(8);
        rst_n = 1'b0;
        #1;
        check("e_rst_level", 32'({level, rise, fall}), 32'h0);
        check("e_rst_evt", 32'({evt_valid, ovf}), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("e_level_early", 32'({level, evt_valid}), 32'h0);
        expect_evt(2'd3, 1'b1);
        tick(1);
        check("e_level", 32'(level), 32'h8);
        check("e_rise", 32'(rise), 32'h8);
        tick(1);
        check("e_valid", 32'(evt_valid), 32'h1);
        tick(2);
        check("e_drained", 32'(evt_valid), 32'h0);

        // Full queue with simultaneous pop and push keeps four entries
        evt_ready = 1'b0;
        pin_in = 4'b0111;
        expect_evt(2'd0, 1'b1);
        expect_evt(2'd1, 1'b1);
        expect_evt(2'd2, 1'b1);
        expect_evt(2'd3, 1'b0);
        tick(16);
        check("f_head", 32'({evt_valid, evt_idx, evt_dir}), 32'b1001);
        pin_in[0] = 1'b0;
        expect_evt(2'd0, 1'b0);
        tick(12);
        check("f_level", 32'(level), 32'h6);
        check("f_head_held", 32'({evt_valid, evt_idx, evt_dir}), 32'b1001);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("f_head_next", 32'({evt_valid, evt_idx, evt_dir}), 32'b1011);
        check("f_ovf", 32'(ovf), 32'h0);
        evt_ready = 1'b1;
        tick(3);
        check("f_tail", 32'({evt_valid, evt_idx, evt_dir}), 32'b1000);
        tick(1);
        check("f_drained", 32'(evt_valid), 32'h0);
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_debounce_rx.md
BUTTON_DEBOUNCE_RX -- requirements
Module: button_debounce_rx

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input pins.
REQ-002 Parameter SYNC_STAGES, default 2, min 2: synchronizer flops per pin.
REQ-003 Parameter LOG2DELAY, default 16: debounce window DELAY = 2^LOG2DELAY cycles.
REQ-004 Parameter FIFO_DEPTH, default 4, power of two: event queue entries.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 pin_in  input  WIDTH  raw asynchronous pad inputs, from input buffers.
REQ-008 level  output  WIDTH  debounced stable level per pin.
REQ-009 rise  output  WIDTH  one-cycle pulse on debounced 0->1.
REQ-010 fall  output  WIDTH  one-cycle pulse on debounced 1->0.
REQ-011 evt_valid  output  1  event queue non-empty.
REQ-012 evt_ready  input  1  consumer accepts head event.
REQ-013 evt_idx  output  clog2(WIDTH)  pin index of head event.
REQ-014 evt_dir  output  1  head event direction, 1 = rise, 0 = fall.
REQ-015 ovf  output  1  sticky: an event was lost.
REQ-016 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-017 Each pin SHALL pass through SYNC_STAGES flops; only the last stage (sync) feeds logic.
REQ-018 Per-pin FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-019 STABLE_LO: sync=1 -> WAIT_HI, counter cleared; STABLE_HI: sync=0 -> WAIT_LO, counter cleared.
REQ-020 WAIT_x: counter increments each cycle sync holds the new value; sync reverts -> back to STABLE state, counter cleared, no event.
REQ-021 WAIT_x: counter = DELAY-1 and sync still new -> enter STABLE of new value; level updates on the same edge.
REQ-022 Total latency from first sampled raw change to level change SHALL be SYNC_STAGES + DELAY + 1 cycles for a clean step.
REQ-023 Counter SHALL be LOG2DELAY bits wide and never wrap; it is held or cleared outside WAIT states.
REQ-024 rise/fall SHALL assert for exactly the one cycle after level changes.
REQ-025 Each level change SHALL set a per-pin pending event (index, direction).
REQ-026 At most one pending event SHALL be pushed per cycle, lowest pin index first, only when the queue is not full.
REQ-027 New event on a pin whose pending event is not yet pushed SHALL replace it and set ovf.
REQ-028 Pop when evt_valid and evt_ready; push and pop in the same cycle SHALL both occur, also when full.
REQ-029 evt_idx/evt_dir SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-030 Queue full: pending events held (REQ-027 applies); empty: evt_valid=0, evt_ready ignored.
REQ-031 ovf_clr coincident with a new loss SHALL leave ovf=1.

Reset
REQ-032 rst_n low SHALL immediately force: sync flops 0, all FSMs STABLE_LO, counters 0, level 0, rise/fall 0, pending cleared, queue empty, evt_valid 0, evt_idx 0, evt_dir 0, ovf 0.
REQ-033 Reset mid-debounce SHALL discard the partial window; no event after release.
REQ-034 After release, a pin held high SHALL produce one rise event after the REQ-022 latency.

Verification (LOG2DELAY=3, DELAY=8, SYNC_STAGES=2, FIFO_DEPTH=4, WIDTH=4)
REQ-035 pin_in[0] 0->1 clean, evt_ready=1 -> level[0]=1 and rise[0] one cycle at 11 cycles; event (idx 0, dir 1) on evt_valid for 1 cycle.
REQ-036 pin_in[1] high 5 cycles then low -> level, rise, evt_valid stay 0.
REQ-037 pins 0..3 rise same cycle, evt_ready=0 -> queue holds idx 0,1,2,3 in order, all dir 1, ovf=0; evt_ready=1 drains 4 beats.
REQ-038 queue full, pin 2 toggles twice before space -> ovf=1, head unchanged; ovf_clr -> ovf=0.
REQ-039 rst_n low at counter=5 in WAIT_HI on pin 3, released with pin high -> no event before 11 cycles after release; one rise then.
REQ-040 full queue, evt_ready=1, new event same cycle -> head popped, new event appended, count stays 4.
